// File: rtl/dmem_store_buffer.sv
// Store buffer between MEM stage and dmem: queues stores, drains them when the
// single memory port is free, and forwards or stalls overlapping loads.
module dmem_store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_stall,
    output logic        fwd_hit,
    output logic [31:0] fwd_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_we,
    output logic        empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [31:0]   e_addr [DEPTH];
    logic [31:0]   e_data [DEPTH];
    logic [1:0]    e_size [DEPTH];

    logic          enq;
    logic          port_load;
    logic          hit_found;
    logic [PW-1:0] hit_idx;
    logic [PW-1:0] idx;
    logic          exact_word;

    // Byte-range intersection; 33-bit sums keep the end addresses from wrapping.
    function automatic logic overlaps(input logic [31:0] ea, input logic [1:0] es,
                                      input logic [31:0] la);
        logic [32:0] e_lo, e_hi, l_lo, l_hi;
        e_lo = {1'b0, ea};
        e_hi = e_lo + (es[1] ? 33'd3 : (es[0] ? 33'd1 : 33'd0));
        l_lo = {1'b0, la};
        l_hi = l_lo + 33'd3;
        return (e_lo <= l_hi) && (l_lo <= e_hi);
    endfunction

    // Walk oldest to youngest so the last overlap seen is the youngest one.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        idx       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && overlaps(e_addr[idx], e_size[idx], ld_addr)) begin
                hit_found = 1'b1;
                hit_idx   = idx;
            end
        end
    end

    always_comb begin
        exact_word = e_size[hit_idx][1] && (e_addr[hit_idx] == ld_addr);
        fwd_hit    = ld_valid && hit_found && exact_word;
        ld_stall   = ld_valid && hit_found && !exact_word;
        fwd_data   = e_data[hit_idx];
        port_load  = ld_valid && !hit_found;
        mem_addr   = port_load ? ld_addr : e_addr[head];
        mem_wdata  = e_data[head];
        mem_size   = e_size[head];
        mem_we     = !port_load && (count != '0);
    end

    assign st_ready = (count < FULL);
    assign empty    = (count == '0);
    assign enq      = st_valid && st_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                e_addr[i] <= '0;
                e_data[i] <= '0;
                e_size[i] <= '0;
            end
        end else begin
            if (enq) begin
                e_addr[tail] <= st_addr;
                e_data[tail] <= st_data;
                e_size[tail] <= st_size;
                tail         <= tail + 1'b1;
            end
            if (mem_we) begin
                head <= head + 1'b1;
            end
            case ({enq, mem_we})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer with a byte-addressed big-endian dmem model.
module tb_dmem_store_buffer;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_we;
    logic        empty;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [7:0]  mem_model [logic [31:0]];

    dmem_store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_size(st_size),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_we(mem_we), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmem model: records every write and stores bytes big-endian
    always @(posedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            case (mem_size)
                2'd0: mem_model[mem_addr] = mem_wdata[7:0];
                2'd1: begin
                    mem_model[mem_addr]         = mem_wdata[15:8];
                    mem_model[mem_addr + 32'd1] = mem_wdata[7:0];
                end
                default: begin
                    mem_model[mem_addr]         = mem_wdata[31:24];
                    mem_model[mem_addr + 32'd1] = mem_wdata[23:16];
                    mem_model[mem_addr + 32'd2] = mem_wdata[15:8];
                    mem_model[mem_addr + 32'd3] = mem_wdata[7:0];
                end
            endcase
        end
    end

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            r = {r[23:0], mem_model.exists(a + 32'(b)) ? mem_model[a + 32'(b)] : 8'h00};
        end
        return r;
    endfunction

    task automatic cyc(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [1:0] ss, input logic lv, input logic [31:0] la);
        @(negedge clk);
        st_valid = sv; st_addr = sa; st_data = sd; st_size = ss;
        ld_valid = lv; ld_addr = la;
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic test_reset();
        int n;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty); end
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL rst_st_ready: got %b want 1", st_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        checks++; if ({ld_stall, fwd_hit} !== 2'b00) begin errors++; $display("FAIL rst_ld_out: got %b want 00", {ld_stall, fwd_hit}); end
        checks++; if ({mem_addr, mem_wdata, mem_size} !== 66'd0) begin errors++; $display("FAIL rst_mem_bus: got %h/%h/%h want 0", mem_addr, mem_wdata, mem_size); end
        @(negedge clk); rst_n = 1'b1;
        // three stores held in the buffer by a non-overlapping load
        cyc(1, 32'h900, 32'h1, 3, 1, 32'h8000);
        cyc(1, 32'h904, 32'h2, 3, 1, 32'h8000);
        cyc(1, 32'h908, 32'h3, 3, 1, 32'h8000);
        cyc(0, 0, 0, 0, 1, 32'h8000);
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL rst_mid_queued: got empty=%b want 0", empty); end
        n = wr_addr.size();
        @(negedge clk); rst_n = 1'b0; ld_valid = 1'b0; #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_async_empty: got %b want 1", empty); end
        @(negedge clk); rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        checks++; if (wr_addr.size() !== n) begin errors++; $display("FAIL rst_no_writes: got %0d writes want %0d", wr_addr.size(), n); end
        checks++; if ({empty, st_ready, mem_we} !== 3'b110) begin errors++; $display("FAIL rst_after: got empty/ready/we=%b want 110", {empty, st_ready, mem_we}); end
    endtask

    task automatic test_basic_drain();
        clear_log();
        cyc(1, 32'h100, 32'hDEADBEEF, 3, 0, 0);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL drain_no_comb: got mem_we=%b want 0", mem_we); end
        cyc(0, 0, 0, 0, 0, 0);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL drain_we: got %b want 1", mem_we); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL drain_addr: got %h want 00000100", mem_addr); end
        checks++; if (mem_size !== 2'd3) begin errors++; $display("FAIL drain_size: got %0d want 3", mem_size); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL drain_wdata: got %h want deadbeef", mem_wdata); end
        cyc(0, 0, 0, 0, 1, 32'h100);
        checks++; if ({ld_stall, fwd_hit, mem_we} !== 3'b000) begin errors++; $display("FAIL drain_load_port: got stall/hit/we=%b want 000", {ld_stall, fwd_hit, mem_we}); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL drain_load_addr: got %h want 00000100", mem_addr); end
        checks++; if (rd_word(32'h100) !== 32'hDEADBEEF) begin errors++; $display("FAIL drain_dmem: got %h want deadbeef", rd_word(32'h100)); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", empty); end
    endtask

    task automatic test_full_wrap();
        clear_log();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'h400 + 32'(4 * i), 32'hA000_0000 + 32'(i), 3, 1, 32'h8000);
            checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %b want 1", i, st_ready); end
        end
        cyc(1, 32'h4F0, 32'h0BAD, 3, 1, 32'h8000);
        checks++; if ({st_ready, mem_we, empty} !== 3'b000) begin errors++; $display("FAIL full_state: got ready/we/empty=%b want 000", {st_ready, mem_we, empty}); end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            checks++; if ({mem_we, mem_addr} !== {1'b1, 32'h400 + 32'(4 * i)}) begin errors++; $display("FAIL full_drain_%0d: got we=%b addr=%h want 1/%h", i, mem_we, mem_addr, 32'h400 + 32'(4 * i)); end
        end
        cyc(0, 0, 0, 0, 0, 0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty: got %b want 1", empty); end
        checks++; if (wr_addr.size() !== 4) begin errors++; $display("FAIL full_write_count: got %0d want 4", wr_addr.size()); end
        clear_log();
        for (int i = 0; i < 6; i++) cyc(1, 32'h440 + 32'(4 * i), 32'hB000_0000 + 32'(i), 3, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        checks++; if (wr_addr.size() !== 6) begin errors++; $display("FAIL wrap_count: got %0d want 6", wr_addr.size()); end
        for (int i = 0; i < 6 && i < wr_addr.size(); i++) begin
            checks++; if ({wr_addr[i], wr_data[i]} !== {32'h440 + 32'(4 * i), 32'hB000_0000 + 32'(i)}) begin errors++; $display("FAIL wrap_order_%0d: got %h/%h want %h/%h", i, wr_addr[i], wr_data[i], 32'h440 + 32'(4 * i), 32'hB000_0000 + 32'(i)); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", empty); end
    endtask

    task automatic test_forwarding();
        clear_log();
        cyc(1, 32'h200, 32'h1111_1111, 3, 1, 32'h8000);
        cyc(1, 32'h200, 32'h2222_2222, 3, 1, 32'h8000);
        cyc(0, 0, 0, 0, 1, 32'h200);
        checks++; if ({fwd_hit, ld_stall} !== 2'b10) begin errors++; $display("FAIL fwd_flags: got hit/stall=%b want 10", {fwd_hit, ld_stall}); end
        checks++; if (fwd_data !== 32'h2222_2222) begin errors++; $display("FAIL fwd_data: got %h want 22222222", fwd_data); end
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h200, 32'h1111_1111}) begin errors++; $display("FAIL fwd_drain: got we=%b %h/%h want 1 00000200/11111111", mem_we, mem_addr, mem_wdata); end
        cyc(0, 0, 0, 0, 0, 0);
        // youngest overlapping entry (a byte) wins over an older exact word
        cyc(1, 32'h500, 32'hCAFE_F00D, 3, 1, 32'h8000);
        cyc(1, 32'h501, 32'h0000_005A, 0, 1, 32'h8000);
        cyc(0, 0, 0, 0, 1, 32'h500);
        checks++; if ({ld_stall, fwd_hit, mem_we} !== 3'b101) begin errors++; $display("FAIL young_stall: got stall/hit/we=%b want 101", {ld_stall, fwd_hit, mem_we}); end
        cyc(0, 0, 0, 0, 1, 32'h500);
        checks++; if ({ld_stall, mem_addr, mem_size} !== {1'b1, 32'h501, 2'd0}) begin errors++; $display("FAIL young_byte: got stall=%b %h size %0d want 1 00000501 0", ld_stall, mem_addr, mem_size); end
        cyc(0, 0, 0, 0, 1, 32'h500);
        checks++; if ({ld_stall, fwd_hit, mem_we} !== 3'b000) begin errors++; $display("FAIL young_clear: got stall/hit/we=%b want 000", {ld_stall, fwd_hit, mem_we}); end
        checks++; if (rd_word(32'h500) !== 32'hCA5A_F00D) begin errors++; $display("FAIL young_dmem: got %h want ca5af00d", rd_word(32'h500)); end
        checks++; if ({wr_addr.size(), empty} !== {32'd4, 1'b1}) begin errors++; $display("FAIL fwd_writes: got %0d writes empty=%b want 4/1", wr_addr.size(), empty); end
    endtask

    task automatic test_partial();
        cyc(1, 32'h302, 32'h0000_ABCD, 1, 1, 32'h8000);
        cyc(0, 0, 0, 0, 1, 32'h300);
        checks++; if ({ld_stall, fwd_hit} !== 2'b10) begin errors++; $display("FAIL part_stall: got stall/hit=%b want 10", {ld_stall, fwd_hit}); end
        checks++; if ({mem_we, mem_addr, mem_size} !== {1'b1, 32'h302, 2'd1}) begin errors++; $display("FAIL part_drain: got we=%b %h size %0d want 1 00000302 1", mem_we, mem_addr, mem_size); end
        cyc(0, 0, 0, 0, 1, 32'h300);
        checks++; if ({ld_stall, fwd_hit, mem_we, mem_addr} !== {3'b000, 32'h300}) begin errors++; $display("FAIL part_release: got stall/hit/we=%b addr %h want 000 00000300", {ld_stall, fwd_hit, mem_we}, mem_addr); end
        checks++; if (rd_word(32'h300) !== 32'h0000_ABCD) begin errors++; $display("FAIL part_dmem: got %h want 0000abcd", rd_word(32'h300)); end
        // bytes just outside and just inside the 4-byte load window
        cyc(1, 32'h2FF, 32'h11, 0, 1, 32'h8000);
        cyc(1, 32'h304, 32'h22, 0, 1, 32'h8000);
        cyc(0, 0, 0, 0, 1, 32'h300);
        checks++; if ({ld_stall, fwd_hit, mem_we} !== 3'b000) begin errors++; $display("FAIL edge_outside: got stall/hit/we=%b want 000", {ld_stall, fwd_hit, mem_we}); end
        cyc(0, 0, 0, 0, 1, 32'h2FC);
        checks++; if (ld_stall !== 1'b1) begin errors++; $display("FAIL edge_low: got stall=%b want 1", ld_stall); end
        cyc(0, 0, 0, 0, 1, 32'h301);
        checks++; if (ld_stall !== 1'b1) begin errors++; $display("FAIL edge_high: got stall=%b want 1", ld_stall); end
        cyc(0, 0, 0, 0, 1, 32'h301);
        checks++; if ({ld_stall, empty} !== 2'b01) begin errors++; $display("FAIL edge_clear: got stall/empty=%b want 01", {ld_stall, empty}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr [5];
        exp_addr = '{32'h600, 32'h604, 32'h608, 32'h700, 32'h704};
        clear_log();
        cyc(1, 32'h600, 32'h60, 3, 1, 32'h8000);
        cyc(1, 32'h604, 32'h64, 3, 1, 32'h8000);
        cyc(1, 32'h608, 32'h68, 3, 0, 0);
        checks++; if ({mem_we, mem_addr} !== {1'b1, 32'h600}) begin errors++; $display("FAIL b2b_drain: got we=%b addr %h want 1 00000600", mem_we, mem_addr); end
        cyc(1, 32'h700, 32'h77, 3, 1, 32'h700);
        checks++; if ({ld_stall, fwd_hit, mem_we} !== 3'b000) begin errors++; $display("FAIL b2b_same_cycle: got stall/hit/we=%b want 000", {ld_stall, fwd_hit, mem_we}); end
        cyc(1, 32'h704, 32'h74, 3, 1, 32'h8000);
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready3: got %b want 1", st_ready); end
        cyc(0, 0, 0, 0, 1, 32'h8000);
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b want 0", st_ready); end
        cyc(0, 0, 0, 0, 1, 32'h700);
        checks++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h77}) begin errors++; $display("FAIL b2b_fwd: got hit=%b data %h want 1 00000077", fwd_hit, fwd_data); end
        checks++; if ({mem_we, mem_addr} !== {1'b1, 32'h604}) begin errors++; $display("FAIL b2b_fwd_drain: got we=%b addr %h want 1 00000604", mem_we, mem_addr); end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
        checks++; if ({wr_addr.size(), empty} !== {32'd5, 1'b1}) begin errors++; $display("FAIL b2b_count: got %0d writes empty=%b want 5/1", wr_addr.size(), empty); end
        for (int i = 0; i < 5 && i < wr_addr.size(); i++) begin
            checks++; if (wr_addr[i] !== exp_addr[i]) begin errors++; $display("FAIL b2b_order_%0d: got %h want %h", i, wr_addr[i], exp_addr[i]); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
        ld_valid = 1'b0; ld_addr = '0;
        test_reset();
        test_basic_drain();
        test_full_wrap();
        test_forwarding();
        test_partial();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Store buffer between the pipeline's MEM stage and the data memory (`dmem`). It queues stores so they retire from the pipeline in one cycle, then drains them to the single memory port when no load is using it. Later loads that overlap a buffered store either receive forwarded data or are stalled.

## Interface
- DEPTH, 4, number of store entries; power of two, at least 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  MEM stage presents a store this cycle.
- st_ready  out  1  a store can be accepted; equals count<DEPTH.
- st_addr  in  32  store byte address, bits [0:31], big-endian.
- st_data  in  32  store data, passed unmodified to memory.
- st_size  in  2  store size: 3=word, 1=halfword, 0=byte; 2 is treated as word.
- ld_valid  in  1  MEM stage presents a load this cycle.
- ld_addr  in  32  load byte address.
- ld_stall  out  1  load must be held; the overlap cannot be forwarded.
- fwd_hit  out  1  load is satisfied from the buffer.
- fwd_data  out  32  forwarded word; valid when fwd_hit=1.
- mem_addr  out  32  to `dmem` addr.
- mem_wdata  out  32  to `dmem` wData.
- mem_size  out  2  to `dmem` dsize.
- mem_we  out  1  to `dmem` writeEnable.
- empty  out  1  buffer holds no stores.

## Operation
- Storage is a circular FIFO with a head pointer, a tail pointer (log2(DEPTH) bits each, wrapping modulo DEPTH) and a count (0..DEPTH).
- **Enqueue:** on a clock edge where st_valid && st_ready, write {addr, data, size} at the tail and advance the tail.
- **Overlap check:** a load always reads 4 bytes, addr..addr+3. Each entry covers addr..addr+N-1, with N=4/2/1 for size 3/1/0. Overlap is byte-range intersection on 32-bit unsigned addresses. Ranges that cross 0xFFFFFFFF are unspecified.
- **Forwarding:** the check covers only registered entries, never the store being enqueued in the same cycle. Entries are searched youngest to oldest. The youngest overlapping entry decides the result:
  - If it is a word store at exactly ld_addr: fwd_hit=1 and fwd_data = that entry's data.
  - Otherwise: ld_stall=1 and fwd_hit=0.
  - If no entry overlaps: both outputs are 0 and the load goes to memory.
- Both outputs are 0 when ld_valid=0.
- **Port arbitration:**
  - port_load = ld_valid && !ld_stall && !fwd_hit.
  - When port_load=1: mem_addr=ld_addr and mem_we=0.
  - Otherwise: mem_addr, mem_wdata and mem_size come from the head entry, and mem_we = (count>0).
- **Drain:** on an edge where mem_we=1, the head is written to `dmem` and the head pointer advances.
- **Forward progress:** a stalled load frees the port, so the conflicting entries drain and the stall always clears.
- **Simultaneous enqueue and drain:** count is unchanged and both pointers advance.
- **Full:** st_ready=0 and the store waits upstream. Drain continues whenever the port is free.
- When count=0 and port_load=0: mem_we=0, and mem_addr, mem_wdata and mem_size are don't-care.

## Timing
- **Reset (async assert, sync-safe deassert):**
  - head=0, tail=0, count=0.
  - st_ready=1, empty=1, mem_we=0, ld_stall=0, fwd_hit=0.
  - mem_addr, mem_wdata and mem_size = 0 unless a load drives mem_addr.
- Reset mid-operation discards every buffered store; none reach `dmem`.
- A store accepted at edge E is:
  - visible to forwarding and overlap checks from cycle E+1;
  - drained at the earliest at edge E+1;
  - observed in `dmem` reads from cycle E+2.
- ld_stall, fwd_hit, fwd_data, mem_* and st_ready are combinational from current inputs and registered state. There are no combinational paths from st_* to the mem_* outputs.
- empty = (count==0), from registered state.
- Continuous loads that miss the buffer starve draining. This is allowed; the pipeline bounds it.

## Test plan
- **Reset:** assert rst_n=0 mid-stream with 3 entries queued, then release -> empty=1, st_ready=1, mem_we=0, and no further writes to `dmem`.
- **Basic drain:** store word 0xDEADBEEF to 0x100, with no loads -> mem_we=1 the next cycle with mem_addr=0x100 and mem_size=3. A load from 0x100 two cycles later returns 0xDEADBEEF from `dmem`.
- **Full and wrap:**
  - Enqueue 4 stores while a load to a non-overlapping address is held every cycle -> st_ready=0 after the 4th store.
  - Release the loads -> the stores drain in FIFO order.
  - Enqueue 6 more -> correct order across the pointer wrap.
- **Forwarding:** store word 0x11111111 then word 0x22222222, both to 0x200, then load 0x200 -> fwd_hit=1, fwd_data=0x22222222, ld_stall=0, and mem_we=1 draining the head in the same cycle.
- **Partial overlap:** store halfword to 0x302, then load 0x300 -> ld_stall=1 until the entry drains, then the load goes to memory with mem_we=0.
- **Simultaneous events:** enqueue and drain in the same cycle with count=2 -> count stays 2. A store enqueued in the same cycle as an overlapping load does not assert ld_stall or fwd_hit.
